// File: rtl/data_ram_arbiter.sv
// Two-port arbiter in front of a single-ported data RAM: port 0 (CPU) and port 1 (loader/DMA) with round-robin and port-1 lock.
// Optional lock timeout enabled by defining ARB_LOCK_TIMEOUT_EN.
module data_ram_arbiter #(
  parameter int LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  input  logic        m1_lock_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_data_o,
  output logic        m1_ack_o,
  output logic [31:0] m1_data_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state, state_nxt;
  logic   last_gnt;      // 1: port 1 was granted most recently
  logic   lock_expired;

  if (LOCK_MAX < 1) begin : g_bad_lock_max
    $error("LOCK_MAX must be at least 1");
  end

`ifdef ARB_LOCK_TIMEOUT_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  // lock_cnt = GNT1 cycles already completed in this tenure; saturates once expired
  logic [CW-1:0] lock_cnt;

  assign lock_expired = (lock_cnt == CNT_LAST) && m0_req_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_cnt <= '0;
    end else if (state == GNT1 && state_nxt == GNT1) begin
      if (lock_cnt != CNT_LAST) lock_cnt <= lock_cnt + 1'b1;
    end else begin
      lock_cnt <= '0;
    end
  end
`else
  assign lock_expired = 1'b0;
`endif

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (m0_req_i && m1_req_i) state_nxt = last_gnt ? GNT0 : GNT1;
        else if (m0_req_i)        state_nxt = GNT0;
        else if (m1_req_i)        state_nxt = GNT1;
        else                      state_nxt = IDLE;
      end
      GNT0:    state_nxt = IDLE;
      GNT1:    state_nxt = (m1_req_i && m1_lock_i && !lock_expired) ? GNT1 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      grant_o  <= 2'b00;
      last_gnt <= 1'b1;
    end else begin
      state   <= state_nxt;
      grant_o <= {state_nxt == GNT1, state_nxt == GNT0};
      if (state_nxt == GNT0) last_gnt <= 1'b0;
      if (state_nxt == GNT1) last_gnt <= 1'b1;
    end
  end

  // Reset held low in a granted cycle suppresses the access so the RAM is not written.
  always_comb begin
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_data_o = '0;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m0_data_o  = '0;
    m1_data_o  = '0;
    case (state)
      GNT0: begin
        ram_ce_o   = m0_req_i && rst;
        ram_we_o   = m0_we_i;
        ram_addr_o = m0_addr_i;
        ram_data_o = m0_data_i;
        m0_ack_o   = m0_req_i && rst;
        m0_data_o  = ram_data_i;
      end
      GNT1: begin
        ram_ce_o   = m1_req_i && rst;
        ram_we_o   = m1_we_i;
        ram_addr_o = m1_addr_i;
        ram_data_o = m1_data_i;
        m1_ack_o   = m1_req_i && rst;
        m1_data_o  = ram_data_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed plus random bench for data_ram_arbiter with a RAM stub and an ownership/memory reference model.
module tb_data_ram_arbiter;

  localparam int LOCK_MAX = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i, m1_lock_i;
  logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
  logic        m0_ack_o, m1_ack_o;
  logic [31:0] m0_data_o, m1_data_o;
  logic        ram_ce_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
  logic [1:0]  grant_o;

  always #5 clk = ~clk;

  data_ram_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
    .m1_lock_i(m1_lock_i),
    .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o), .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .ram_data_i(ram_data_i), .grant_o(grant_o)
  );

  // RAM stub: combinational read, clocked write, 256 words
  logic [31:0] ram [256];
  assign ram_data_i = ram[ram_addr_o[9:2]];
  always @(posedge clk) if (ram_ce_o && ram_we_o) ram[ram_addr_o[9:2]] <= ram_data_o;

  int vecs = 0;
  int errs = 0;

  // model: owner 0 idle / 1 port 0 / 2 port 1; last = port granted most recently; run = GNT1 cycles in tenure
  int          owner = 0;
  int          last  = 1;
  int          run   = 0;
  logic [31:0] ref_mem [int];
  logic        exp_ack0, exp_ack1;
  logic [1:0]  seen_grant;
  logic        seen_ack0, seen_ack1;
  logic [31:0] seen_d0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic act, r, w;
    logic [31:0] a, d;
    int idx, nxt;
    @(negedge clk);
    vecs++;
    act = rst && owner != 0;
    r   = (owner == 1) ? m0_req_i : (owner == 2) ? m1_req_i : 1'b0;
    w   = (owner == 1) ? m0_we_i : m1_we_i;
    a   = (owner == 1) ? m0_addr_i : m1_addr_i;
    d   = (owner == 1) ? m0_data_i : m1_data_i;
    idx = int'(a[9:2]);
    exp_ack0 = act && owner == 1 && r;
    exp_ack1 = act && owner == 2 && r;
    chk("grant", 32'(grant_o), (owner == 1) ? 32'd1 : (owner == 2) ? 32'd2 : 32'd0);
    chk("m0_ack", 32'(m0_ack_o), 32'(exp_ack0));
    chk("m1_ack", 32'(m1_ack_o), 32'(exp_ack1));
    chk("ram_ce", 32'(ram_ce_o), 32'(act && r));
    if (owner == 0) begin
      chk("idle_we", 32'(ram_we_o), 32'd0);
      chk("idle_addr", ram_addr_o, 32'd0);
      chk("idle_wdata", ram_data_o, 32'd0);
      chk("idle_d0", m0_data_o, 32'd0);
      chk("idle_d1", m1_data_o, 32'd0);
    end else if (act && r) begin
      chk("ram_we", 32'(ram_we_o), 32'(w));
      chk("ram_addr", ram_addr_o, a);
      if (w) chk("ram_wdata", ram_data_o, d);
      else if (ref_mem.exists(idx))
        chk("rdata", (owner == 1) ? m0_data_o : m1_data_o, ref_mem[idx]);
    end
    seen_grant = grant_o;
    seen_ack0  = m0_ack_o;
    seen_ack1  = m1_ack_o;
    seen_d0    = m0_data_o;
    @(posedge clk);
    if ((exp_ack0 || exp_ack1) && w) ref_mem[idx] = d;
    if (!rst) begin
      owner = 0; last = 1; run = 0;
    end else begin
      case (owner)
        0: if (m0_req_i && m1_req_i) nxt = (last == 1) ? 1 : 2;
           else if (m0_req_i) nxt = 1;
           else if (m1_req_i) nxt = 2;
           else nxt = 0;
        1: nxt = 0;
        default: begin
          nxt = (m1_req_i && m1_lock_i) ? 2 : 0;
`ifdef ARB_LOCK_TIMEOUT_EN
          if (run >= LOCK_MAX && m0_req_i) nxt = 0;
`endif
        end
      endcase
      if (nxt == 1) last = 0;
      if (nxt == 2) last = 1;
      run = (nxt == 2) ? run + 1 : 0;
      owner = nxt;
    end
    #1;
  endtask

  task automatic p0(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    m0_req_i = req; m0_we_i = we; m0_addr_i = a; m0_data_i = d;
  endtask

  task automatic p1(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d,
                    input logic lock);
    m1_req_i = req; m1_we_i = we; m1_addr_i = a; m1_data_i = d; m1_lock_i = lock;
  endtask

  initial begin
    int n;
    logic pend0, pend1;
    rst = 1'b0;
    p0(0, 0, 0, 0);
    p1(0, 0, 0, 0, 0);
    #1;
    cycle(); cycle();
    rst = 1'b1;
    cycle();
    chk("reset_grant", 32'(seen_grant), 32'd0);

    // port 0 write then read back
    p0(1, 1, 32'h10, 32'h1234_5678);
    cycle();
    chk("wr_wait", 32'(seen_ack0), 32'd0);
    cycle();
    chk("wr_grant", 32'(seen_grant), 32'd1);
    chk("wr_ack", 32'(seen_ack0), 32'd1);
    p0(1, 0, 32'h10, 32'h0);
    cycle(); cycle();
    chk("rd_ack", 32'(seen_ack0), 32'd1);
    chk("rd_data", seen_d0, 32'h1234_5678);
    p0(0, 0, 0, 0);
    cycle();

    // simultaneous requests right after reset alternate 0,1,0,1
    rst = 1'b0; cycle(); rst = 1'b1;
    p0(1, 1, 32'h100, 32'hA0A0_0000);
    p1(1, 1, 32'h104, 32'hB0B0_0000, 0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      cycle();
      chk("rr_grant", 32'(seen_grant), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    p0(0, 0, 0, 0);
    p1(0, 0, 0, 0, 0);
    cycle();

    // locked 4-word burst from port 1
    p1(1, 1, 32'h20, 32'hC000_0020, 1);
    cycle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("burst_grant", 32'(seen_grant), 32'd2);
      chk("burst_ack", 32'(seen_ack1), 32'd1);
      p1(i < 3, 1, 32'h24 + 32'(4 * i), 32'hC000_0024 + 32'(4 * i), i < 2);
    end
    cycle();
    chk("burst_end", 32'(seen_grant), 32'd0);
    p0(1, 0, 32'h2C, 0);
    cycle(); cycle();
    chk("burst_rd", seen_d0, 32'hC000_002C);
    p0(0, 0, 0, 0);
    cycle();

    // lock held while port 0 waits
    p0(1, 0, 32'h10, 0);
    p1(1, 1, 32'h80, 32'hD00D_0080, 1);
    n = 0;
    while (seen_grant != 2'b10 && n < 6) begin cycle(); n++; end
    chk("lock_enter", 32'(seen_grant), 32'd2);
    n = 0;
    while (seen_grant == 2'b10 && n < 40) begin cycle(); n++; end
`ifdef ARB_LOCK_TIMEOUT_EN
    chk("lock_len", 32'(n), 32'(LOCK_MAX));
    chk("lock_exit", 32'(seen_grant), 32'd0);
    cycle();
    chk("lock_p0_grant", 32'(seen_grant), 32'd1);
    chk("lock_p0_ack", 32'(seen_ack0), 32'd1);
`else
    chk("lock_hold", 32'(n), 32'd40);
`endif
    p0(0, 0, 0, 0);
    p1(0, 0, 0, 0, 0);
    cycle(); cycle();

    // reset in the middle of a port 1 write leaves memory untouched
    p0(1, 1, 32'h40, 32'h0000_AAAA);
    cycle(); cycle();
    p0(0, 0, 0, 0);
    p1(1, 1, 32'h40, 32'h0000_BBBB, 0);
    cycle();
    rst = 1'b0;
    cycle();
    chk("rst_no_ack", 32'(seen_ack1), 32'd0);
    rst = 1'b1;
    p1(0, 0, 0, 0, 0);
    cycle();
    chk("rst_grant", 32'(seen_grant), 32'd0);
    p0(1, 0, 32'h40, 0);
    cycle(); cycle();
    chk("rst_mem", seen_d0, 32'h0000_AAAA);
    p0(0, 0, 0, 0);
    cycle();

    // random traffic, requesters hold until acked
    pend0 = 1'b0; pend1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!pend0) begin
        pend0 = ($urandom_range(0, 1) == 1);
        p0(pend0, 1'($urandom), {22'd0, 8'($urandom), 2'b00}, $urandom);
      end
      if (!pend1) begin
        pend1 = ($urandom_range(0, 2) != 0);
        p1(pend1, 1'($urandom), {22'd0, 8'($urandom), 2'b00}, $urandom, pend1 && ($urandom_range(0, 3) != 0));
      end
      rst = ($urandom_range(0, 63) != 0);
      cycle();
      if (exp_ack0) pend0 = 1'b0;
      if (exp_ack1) pend1 = 1'b0;
    end
    rst = 1'b1;
    p0(0, 0, 0, 0);
    p1(0, 0, 0, 0, 0);
    cycle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
